// File: rtl/fnd_pkg.sv
// Shared definitions for the FND scan scheduler.
//   state_t      : scheduler FSM states
//   DIGIT_POS_W  : width of the digit-position index
//   NUM_DIGITS   : digits on the display
//   BCD_W        : width of one BCD nibble
//   lz_suppress(): leading-zero blanking decision for one digit position
package fnd_pkg;

  localparam int DIGIT_POS_W = 2;
  localparam int NUM_DIGITS  = 4;
  localparam int BCD_W       = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  // A digit is suppressed when it and every digit to its left are zero.
  // Digit 0 always shows so that a value of zero still displays "0".
  function automatic logic lz_suppress(
    input logic [NUM_DIGITS*BCD_W-1:0] digits,
    input logic [DIGIT_POS_W-1:0]      pos
  );
    logic d3_z, d2_z, d1_z;
    d3_z = (digits[15:12] == 4'd0);
    d2_z = (digits[11:8]  == 4'd0);
    d1_z = (digits[7:4]   == 4'd0);
    case (pos)
      2'd3:    lz_suppress = d3_z;
      2'd2:    lz_suppress = d3_z & d2_z;
      2'd1:    lz_suppress = d3_z & d2_z & d1_z;
      default: lz_suppress = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fnd_slot_counter.sv
// Modulo-DIV cycle counter for one digit slot.
//   clk, rst_n  : clock, async active-low reset
//   clear       : synchronous clear to 0 (wins over inc)
//   inc         : advance the count, wrapping DIV-1 -> 0
//   blank_done  : count == BLANK-1 (last blanked cycle of the slot)
//   slot_done   : count == DIV-1   (last cycle of the slot)
module fnd_slot_counter #(
  parameter int unsigned DIV   = 100_000,
  parameter int unsigned BLANK = 1_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc,
  output logic blank_done,
  output logic slot_done
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);

  logic [CW-1:0] count;

  assign blank_done = (count == BLANK_LAST);
  assign slot_done  = (count == SLOT_LAST);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= slot_done ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/fnd_scan_scheduler.sv
// Time-multiplexing scan scheduler for a 4-digit FND.
//   i_clk, i_reset    : clock, async active-low reset
//   i_en              : scan enable; 0 parks the scheduler in IDLE
//   i_digits          : four BCD digits, [3:0] = rightmost digit 0
//   i_blinkMask       : per-digit blink enable
//   i_dotMask         : per-digit decimal point
//   i_lzs             : leading-zero suppression enable
//   o_digitPosition   : selected digit, drives the 2-to-4 decoder
//   o_bcd, o_dp       : nibble and DP of the selected digit
//   o_blank           : 1 = segments dark this cycle
//   o_frameStart      : one-cycle pulse as the digit 0 slot begins
// Inputs are captured into shadow registers only at frame boundaries so a
// frame is always drawn from one coherent snapshot.
module fnd_scan_scheduler
  import fnd_pkg::*;
#(
  parameter int unsigned DIV          = 100_000,
  parameter int unsigned BLANK        = 1_000,
  parameter int unsigned BLINK_FRAMES = 125
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_en,
  input  logic [NUM_DIGITS*BCD_W-1:0]   i_digits,
  input  logic [NUM_DIGITS-1:0]         i_blinkMask,
  input  logic [NUM_DIGITS-1:0]         i_dotMask,
  input  logic                          i_lzs,
  output logic [DIGIT_POS_W-1:0]        o_digitPosition,
  output logic [BCD_W-1:0]              o_bcd,
  output logic                          o_dp,
  output logic                          o_blank,
  output logic                          o_frameStart
);

  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  state_t                        state, state_n;
  logic [DIGIT_POS_W-1:0]        pos_n;
  logic [NUM_DIGITS*BCD_W-1:0]   sh_digits, sh_digits_n;
  logic [NUM_DIGITS-1:0]         sh_blink, sh_blink_n;
  logic [NUM_DIGITS-1:0]         sh_dot, sh_dot_n;
  logic                          sh_lzs, sh_lzs_n;
  logic [FW-1:0]                 frame_cnt, frame_cnt_n;
  logic                          phase, phase_n;
  logic                          load, frame_tick;
  logic                          blank_done, slot_done;
  logic [BCD_W-1:0]              bcd_n;
  logic                          dp_n, blank_n;

  // The counter is held at 0 in IDLE and whenever the scheduler drops to IDLE.
  fnd_slot_counter #(
    .DIV   (DIV),
    .BLANK (BLANK)
  ) u_slot_counter (
    .clk        (i_clk),
    .rst_n      (i_reset),
    .clear      ((state == ST_IDLE) || (state_n == ST_IDLE)),
    .inc        (1'b1),
    .blank_done (blank_done),
    .slot_done  (slot_done)
  );

  // NOTE: every signal driven here gets a default first; a missed branch
  // would otherwise infer a latch.
  always_comb begin
    state_n    = state;
    pos_n      = o_digitPosition;
    load       = 1'b0;
    frame_tick = 1'b0;

    // Disable has priority, so a falling i_en on a slot wrap neither reloads
    // the shadows nor pulses o_frameStart.
    if (!i_en) begin
      state_n = ST_IDLE;
      pos_n   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_n = ST_BLANK;
          pos_n   = '0;
          load    = 1'b1;
        end
        ST_BLANK: begin
          if (blank_done) state_n = ST_SHOW;
        end
        ST_SHOW: begin
          if (slot_done) begin
            state_n = ST_BLANK;
            pos_n   = o_digitPosition + 2'd1;
            if (o_digitPosition == 2'd3) begin
              load       = 1'b1;
              frame_tick = 1'b1;
            end
          end
        end
        default: begin
          state_n = ST_IDLE;
          pos_n   = '0;
        end
      endcase
    end

    sh_digits_n = load ? i_digits    : sh_digits;
    sh_blink_n  = load ? i_blinkMask : sh_blink;
    sh_dot_n    = load ? i_dotMask   : sh_dot;
    sh_lzs_n    = load ? i_lzs       : sh_lzs;

    frame_cnt_n = frame_cnt;
    phase_n     = phase;
    if (frame_tick) begin
      if (frame_cnt == FRAME_LAST) begin
        frame_cnt_n = '0;
        phase_n     = ~phase;
      end else begin
        frame_cnt_n = frame_cnt + FW'(1);
      end
    end

    // Outputs are computed from next-state values so the registered outputs
    // line up with the registered position on the same edge.
    bcd_n   = sh_digits_n[{pos_n, 2'b00} +: BCD_W];
    dp_n    = sh_dot_n[pos_n];
    blank_n = (state_n != ST_SHOW)
            | (sh_blink_n[pos_n] & phase_n)
            | (sh_lzs_n & lz_suppress(sh_digits_n, pos_n));
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state           <= ST_IDLE;
      o_digitPosition <= '0;
      sh_digits       <= '0;
      sh_blink        <= '0;
      sh_dot          <= '0;
      sh_lzs          <= 1'b0;
      frame_cnt       <= '0;
      phase           <= 1'b0;
      o_bcd           <= '0;
      o_dp            <= 1'b0;
      o_blank         <= 1'b1;
      o_frameStart    <= 1'b0;
    end else begin
      state           <= state_n;
      o_digitPosition <= pos_n;
      sh_digits       <= sh_digits_n;
      sh_blink        <= sh_blink_n;
      sh_dot          <= sh_dot_n;
      sh_lzs          <= sh_lzs_n;
      frame_cnt       <= frame_cnt_n;
      phase           <= phase_n;
      o_bcd           <= bcd_n;
      o_dp            <= dp_n;
      o_blank         <= blank_n;
      o_frameStart    <= load;
    end
  end

endmodule

// File: tb/tb_fnd_scan_scheduler.sv
// Self-checking bench for fnd_scan_scheduler (DIV=8, BLANK=2, BLINK_FRAMES=2).
module tb_fnd_scan_scheduler;

  localparam int DIV          = 8;
  localparam int BLANK        = 2;
  localparam int BLINK_FRAMES = 2;
  localparam int FRAME        = 4 * DIV;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_en;
  logic [15:0] i_digits;
  logic [3:0]  i_blinkMask;
  logic [3:0]  i_dotMask;
  logic        i_lzs;
  logic [1:0]  o_digitPosition;
  logic [3:0]  o_bcd;
  logic        o_dp;
  logic        o_blank;
  logic        o_frameStart;

  fnd_scan_scheduler #(
    .DIV          (DIV),
    .BLANK        (BLANK),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) dut (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .i_en            (i_en),
    .i_digits        (i_digits),
    .i_blinkMask     (i_blinkMask),
    .i_dotMask       (i_dotMask),
    .i_lzs           (i_lzs),
    .o_digitPosition (o_digitPosition),
    .o_bcd           (o_bcd),
    .o_dp            (o_dp),
    .o_blank         (o_blank),
    .o_frameStart    (o_frameStart)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [1:0] pos;
    logic [3:0] bcd;
    logic       dp;
    logic       blank;
    logic       fs;
    bit         chk_data;
  } exp_t;

  typedef struct {
    logic [15:0] digits;
    logic [3:0]  blink;
    logic [3:0]  dot;
    logic        lzs;
    logic [15:0] exp_bcd;   // expected nibble per position
    logic [3:0]  exp_dp;    // expected DP per position
    logic [3:0]  exp_lzb;   // positions expected dark for the whole slot
  } vec_t;

  exp_t sb[$];
  vec_t vecs[7];

  // Reference model of the shadow snapshot and the run position.
  logic [15:0] m_digits;
  logic [3:0]  m_blink, m_dot;
  logic        m_lzs;
  int          m_t;
  int          m_frames0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Advance one clock, then compare the oldest scoreboard entry.
  task automatic sample();
    exp_t e;
    @(posedge i_clk);
    #1;
    e = sb.pop_front();
    check("pos", 16'(o_digitPosition), 16'(e.pos));
    check("blank", 16'(o_blank), 16'(e.blank));
    check("frame_start", 16'(o_frameStart), 16'(e.fs));
    if (e.chk_data) begin
      check("bcd", 16'(o_bcd), 16'(e.bcd));
      check("dp", 16'(o_dp), 16'(e.dp));
    end
  endtask

  task automatic push_idle(input bit chk_data);
    exp_t e;
    e.pos = 2'd0; e.bcd = 4'd0; e.dp = 1'b0; e.blank = 1'b1; e.fs = 1'b0;
    e.chk_data = chk_data;
    sb.push_back(e);
    sample();
  endtask

  function automatic bit lz_model(input logic [15:0] d, input int pos);
    if (pos == 0) return 1'b0;
    for (int k = pos; k < 4; k++)
      if (d[k*4 +: 4] != 4'd0) return 1'b0;
    return 1'b1;
  endfunction

  // One enabled cycle predicted from elapsed time since enable.
  task automatic model_step();
    exp_t e;
    int   pos, in_slot, phase;
    if (m_t % FRAME == 0) begin
      m_digits = i_digits; m_blink = i_blinkMask; m_dot = i_dotMask; m_lzs = i_lzs;
    end
    pos     = (m_t / DIV) % 4;
    in_slot = m_t % DIV;
    phase   = ((m_frames0 + m_t / FRAME) / BLINK_FRAMES) % 2;
    e.pos   = 2'(pos);
    e.bcd   = m_digits[pos*4 +: 4];
    e.dp    = m_dot[pos];
    e.blank = (in_slot < BLANK) || (m_blink[pos] && phase == 1) ||
              (m_lzs && lz_model(m_digits, pos));
    e.fs    = (m_t % FRAME == 0);
    e.chk_data = 1'b1;
    sb.push_back(e);
    sample();
    m_t++;
  endtask

  task automatic do_reset();
    i_en = 1'b0;
    i_reset = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    i_reset = 1'b1;
    m_frames0 = 0;
  endtask

  task automatic start_run();
    i_en = 1'b1;
    m_t  = 0;
  endtask

  initial begin
    vecs[0] = '{16'h1234, 4'b0000, 4'b0000, 1'b0, 16'h1234, 4'b0000, 4'b0000};
    vecs[1] = '{16'h0005, 4'b0000, 4'b0000, 1'b1, 16'h0005, 4'b0000, 4'b1110};
    vecs[2] = '{16'h0005, 4'b0000, 4'b0000, 1'b0, 16'h0005, 4'b0000, 4'b0000};
    vecs[3] = '{16'h0040, 4'b0000, 4'b1111, 1'b1, 16'h0040, 4'b1111, 4'b1100};
    vecs[4] = '{16'h00A0, 4'b0000, 4'b0100, 1'b1, 16'h00A0, 4'b0100, 4'b1100};
    vecs[5] = '{16'h0000, 4'b0000, 4'b0001, 1'b1, 16'h0000, 4'b0001, 4'b1110};
    vecs[6] = '{16'h9000, 4'b0000, 4'b1000, 1'b1, 16'h9000, 4'b1000, 4'b0000};

    i_reset = 1'b1; i_en = 1'b0; i_digits = 16'h0;
    i_blinkMask = 4'h0; i_dotMask = 4'h0; i_lzs = 1'b0;
    m_frames0 = 0; m_t = 0;

    // Reset values, then 50 idle cycles with the scheduler disabled.
    #2 i_reset = 1'b0;
    #1;
    check("rst_blank", 16'(o_blank), 16'd1);
    check("rst_pos", 16'(o_digitPosition), 16'd0);
    check("rst_bcd", 16'(o_bcd), 16'd0);
    check("rst_fs", 16'(o_frameStart), 16'd0);
    repeat (2) @(posedge i_clk);
    #1 i_reset = 1'b1;
    repeat (50) push_idle(1'b1);

    // Table-driven single frames plus the first cycle of the next frame.
    for (int i = 0; i < 7; i++) begin
      do_reset();
      i_digits = vecs[i].digits; i_blinkMask = vecs[i].blink;
      i_dotMask = vecs[i].dot; i_lzs = vecs[i].lzs;
      i_en = 1'b1;
      for (int t = 0; t <= FRAME; t++) begin
        exp_t e;
        int   pos;
        pos = (t / DIV) % 4;
        e.pos   = 2'(pos);
        e.bcd   = vecs[i].exp_bcd[pos*4 +: 4];
        e.dp    = vecs[i].exp_dp[pos];
        e.blank = ((t % DIV) < BLANK) || vecs[i].exp_lzb[pos];
        e.fs    = (t % FRAME == 0);
        e.chk_data = 1'b1;
        sb.push_back(e);
        sample();
      end
    end

    // Mid-frame input change is deferred to the next frame.
    do_reset();
    i_digits = 16'h1234; i_blinkMask = 4'h0; i_dotMask = 4'h0; i_lzs = 1'b0;
    start_run();
    for (int k = 0; k < 2 * FRAME; k++) begin
      if (m_t == 12) i_digits = 16'h5678;
      model_step();
    end

    // Blink on digit 0 across five frames: visible, visible, dark, dark, visible.
    do_reset();
    i_digits = 16'h1234; i_blinkMask = 4'b0001; i_dotMask = 4'b0001;
    start_run();
    repeat (5 * FRAME + 1) model_step();

    // Disable at cycle 5 of position 2, then re-enable with new data.
    do_reset();
    i_digits = 16'h1234; i_blinkMask = 4'h0; i_dotMask = 4'h0;
    start_run();
    repeat (2 * DIV + 6) model_step();
    i_en = 1'b0;
    repeat (4) push_idle(1'b0);
    i_digits = 16'h4321;
    start_run();
    repeat (DIV + 2) model_step();

    // Disable exactly on the frame wrap edge: IDLE, no frameStart.
    do_reset();
    i_digits = 16'h1234;
    start_run();
    repeat (FRAME) model_step();
    i_en = 1'b0;
    repeat (3) push_idle(1'b0);

    // Async reset in the middle of a SHOW interval.
    do_reset();
    i_digits = 16'h1234;
    start_run();
    repeat (5) model_step();
    #2 i_reset = 1'b0;
    #1;
    check("arst_blank", 16'(o_blank), 16'd1);
    check("arst_pos", 16'(o_digitPosition), 16'd0);
    check("arst_bcd", 16'(o_bcd), 16'd0);
    check("arst_dp", 16'(o_dp), 16'd0);
    check("arst_fs", 16'(o_frameStart), 16'd0);
    i_en = 1'b0;
    @(posedge i_clk);
    #1 i_reset = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
